// File: rtl/algo_1r2w_a63_mem_pkg.sv
// Shared types and helpers for the 1R2W a63 physical memory bank model.
package algo_1r2w_a63_mem_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } mem_state_t;

    localparam int COLLCNT_W = 16;

    function automatic logic [COLLCNT_W-1:0] sat_add(
        input logic [COLLCNT_W-1:0] a,
        input logic [COLLCNT_W-1:0] b
    );
        logic [COLLCNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[COLLCNT_W] ? {COLLCNT_W{1'b1}} : s[COLLCNT_W-1:0];
    endfunction

endpackage

// File: rtl/algo_1r2w_a63_mem_sbank.sv
// One 1W1R bank: masked write, read-before-write, SRAM_DELAY-stage read pipe; no backpressure.
// Optional read XOR port when MEMOIR_MEM_ERRINJ_EN is defined.
module algo_1r2w_a63_mem_sbank #(
    parameter int BITSROW    = 10,
    parameter int NUMSROW    = 745,
    parameter int PHYWDTH    = 32,
    parameter int SRAM_DELAY = 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_init,
    input  logic [BITSROW-1:0] i_init_row,
    input  logic               i_wr,
    input  logic [BITSROW-1:0] i_wr_addr,
    input  logic [PHYWDTH-1:0] i_wr_dat,
    input  logic [PHYWDTH-1:0] i_wr_bw,
    input  logic               i_rd,
    input  logic               i_rd_inrng,
    input  logic [BITSROW-1:0] i_rd_addr,
`ifdef MEMOIR_MEM_ERRINJ_EN
    input  logic [PHYWDTH-1:0] i_rd_xor,
`endif
    output logic [PHYWDTH-1:0] o_rd_dat,
    output logic               o_coll
);

    logic [PHYWDTH-1:0]    r_mem [NUMSROW];
    logic [PHYWDTH-1:0]    r_dat [SRAM_DELAY];
    logic [PHYWDTH-1:0]    w_rdata;
    logic [SRAM_DELAY-1:0] w_ld;

    // Storage is deliberately not reset; the top-level init sweep clears it.
    always_ff @(posedge i_clk) begin
        if (i_init) begin
            r_mem[i_init_row] <= '0;
        end else if (i_wr) begin
            r_mem[i_wr_addr] <= (r_mem[i_wr_addr] & ~i_wr_bw) | (i_wr_dat & i_wr_bw);
        end
    end

    always_comb begin
        w_rdata = '0;
        if (i_rd_inrng) begin
`ifdef MEMOIR_MEM_ERRINJ_EN
            w_rdata = r_mem[i_rd_addr] ^ i_rd_xor;
`else
            w_rdata = r_mem[i_rd_addr];
`endif
        end
    end

    assign o_coll = i_wr & i_rd & i_rd_inrng & (i_wr_addr == i_rd_addr);

    generate
        if (SRAM_DELAY > 1) begin : g_vld
            logic [SRAM_DELAY-2:0] r_vld;
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_vld <= '0;
                end else begin
                    r_vld[0] <= i_rd;
                    for (int i = 1; i < SRAM_DELAY-1; i++) begin
                        r_vld[i] <= r_vld[i-1];
                    end
                end
            end
            assign w_ld = {r_vld, i_rd};
        end else begin : g_novld
            assign w_ld = i_rd;
        end
    endgenerate

    // Each stage only advances on a valid read, so the last stage holds between reads.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < SRAM_DELAY; i++) begin
                r_dat[i] <= '0;
            end
        end else begin
            if (w_ld[0]) begin
                r_dat[0] <= w_rdata;
            end
            for (int i = 1; i < SRAM_DELAY; i++) begin
                if (w_ld[i]) begin
                    r_dat[i] <= r_dat[i-1];
                end
            end
        end
    end

    assign o_rd_dat = r_dat[SRAM_DELAY-1];

endmodule

// File: rtl/algo_1r2w_a63_mem_bank.sv
// NUMVBNK-bank 1R2W a63 memory responder with zero-init FSM; read latency SRAM_DELAY; no backpressure.
// Optional error injection on reads when MEMOIR_MEM_ERRINJ_EN is defined.
module algo_1r2w_a63_mem_bank
    import algo_1r2w_a63_mem_pkg::*;
#(
    parameter  int NUMVBNK    = 4,
    parameter  int BITSROW    = 10,
    parameter  int NUMSROW    = 745,
    parameter  int PHYWDTH    = 32,
    parameter  int SRAM_DELAY = 1,
    localparam int BNKW       = (NUMVBNK > 1) ? $clog2(NUMVBNK) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUMVBNK-1:0]         t1_writeA,
    input  logic [NUMVBNK*BITSROW-1:0] t1_addrA,
    input  logic [NUMVBNK*PHYWDTH-1:0] t1_dinA,
    input  logic [NUMVBNK*PHYWDTH-1:0] t1_bwA,
    input  logic [NUMVBNK-1:0]         t1_readB,
    input  logic [NUMVBNK*BITSROW-1:0] t1_addrB,
`ifdef MEMOIR_MEM_ERRINJ_EN
    input  logic                       errinj_en,
    input  logic [BNKW-1:0]            errinj_bnk,
    input  logic [BITSROW-1:0]         errinj_row,
    input  logic [PHYWDTH-1:0]         errinj_mask,
`endif
    output logic [NUMVBNK*PHYWDTH-1:0] t1_doutB,
    output logic                       ready,
    output logic [COLLCNT_W-1:0]       coll_cnt,
    output logic                       oor_err
);

    localparam logic [BITSROW:0]   ROWS     = (BITSROW+1)'(NUMSROW);
    localparam logic [BITSROW-1:0] LAST_ROW = BITSROW'(NUMSROW-1);

    mem_state_t           r_state;
    logic [BITSROW-1:0]   r_cnt;
    logic                 r_ready;
    logic                 r_oor;
    logic [COLLCNT_W-1:0] r_coll_cnt;
    logic [COLLCNT_W-1:0] w_coll_sum;
    logic                 w_run;
    logic [NUMVBNK-1:0]   w_wr;
    logic [NUMVBNK-1:0]   w_rd;
    logic [NUMVBNK-1:0]   w_rd_inrng;
    logic [NUMVBNK-1:0]   w_coll;
    logic [NUMVBNK-1:0]   w_oor;

    assign w_run = (r_state == ST_RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (r_cnt == LAST_ROW) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RUN: r_ready <= 1'b1;
            endcase
        end
    end

    for (genvar b = 0; b < NUMVBNK; b++) begin : g_bank
        logic [BITSROW-1:0] w_addr_a;
        logic [BITSROW-1:0] w_addr_b;
        logic               w_a_inrng;

        assign w_addr_a      = t1_addrA[b*BITSROW +: BITSROW];
        assign w_addr_b      = t1_addrB[b*BITSROW +: BITSROW];
        assign w_a_inrng     = {1'b0, w_addr_a} < ROWS;
        assign w_rd_inrng[b] = {1'b0, w_addr_b} < ROWS;
        assign w_wr[b]       = w_run & t1_writeA[b] & w_a_inrng;
        assign w_rd[b]       = w_run & t1_readB[b];
        assign w_oor[b]      = w_run & ((t1_writeA[b] & ~w_a_inrng) |
                                        (t1_readB[b]  & ~w_rd_inrng[b]));
`ifdef MEMOIR_MEM_ERRINJ_EN
        logic [PHYWDTH-1:0] w_xor;
        assign w_xor = (errinj_en && errinj_bnk == BNKW'(b) && errinj_row == w_addr_b) ?
                       errinj_mask : '0;
`endif

        algo_1r2w_a63_mem_sbank #(
            .BITSROW    (BITSROW),
            .NUMSROW    (NUMSROW),
            .PHYWDTH    (PHYWDTH),
            .SRAM_DELAY (SRAM_DELAY)
        ) u_sbank (
            .i_clk      (clk),
            .i_rst_n    (rst),
            .i_init     (~w_run),
            .i_init_row (r_cnt),
            .i_wr       (w_wr[b]),
            .i_wr_addr  (w_addr_a),
            .i_wr_dat   (t1_dinA[b*PHYWDTH +: PHYWDTH]),
            .i_wr_bw    (t1_bwA[b*PHYWDTH +: PHYWDTH]),
            .i_rd       (w_rd[b]),
            .i_rd_inrng (w_rd_inrng[b]),
            .i_rd_addr  (w_addr_b),
`ifdef MEMOIR_MEM_ERRINJ_EN
            .i_rd_xor   (w_xor),
`endif
            .o_rd_dat   (t1_doutB[b*PHYWDTH +: PHYWDTH]),
            .o_coll     (w_coll[b])
        );
    end

    always_comb begin
        w_coll_sum = '0;
        for (int b = 0; b < NUMVBNK; b++) begin
            w_coll_sum = w_coll_sum + COLLCNT_W'(w_coll[b]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_coll_cnt <= '0;
            r_oor      <= 1'b0;
        end else begin
            r_coll_cnt <= sat_add(r_coll_cnt, w_coll_sum);
            r_oor      <= r_oor | (|w_oor);
        end
    end

    assign ready    = r_ready;
    assign coll_cnt = r_coll_cnt;
    assign oor_err  = r_oor;

endmodule

// File: tb/tb_algo_1r2w_a63_mem_bank.sv
// Directed bench for algo_1r2w_a63_mem_bank: a default instance plus an SRAM_DELAY=3 instance on shared inputs.
module tb_algo_1r2w_a63_mem_bank;

    localparam int NB = 4;
    localparam int BR = 10;
    localparam int PW = 32;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [NB-1:0]      wa, rb;
    logic [NB*BR-1:0]   aa, ab;
    logic [NB*PW-1:0]   da, bw;
    logic [NB*PW-1:0]   dout1, dout3;
    logic               rdy1, rdy3, oor1, oor3;
    logic [15:0]        cc1, cc3;
`ifdef MEMOIR_MEM_ERRINJ_EN
    logic               ei_en = 1'b0;
    logic [1:0]         ei_bnk = '0;
    logic [BR-1:0]      ei_row = '0;
    logic [PW-1:0]      ei_mask = '0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    algo_1r2w_a63_mem_bank u_dut (
        .clk(clk), .rst(rst),
        .t1_writeA(wa), .t1_addrA(aa), .t1_dinA(da), .t1_bwA(bw),
        .t1_readB(rb), .t1_addrB(ab),
`ifdef MEMOIR_MEM_ERRINJ_EN
        .errinj_en(ei_en), .errinj_bnk(ei_bnk), .errinj_row(ei_row), .errinj_mask(ei_mask),
`endif
        .t1_doutB(dout1), .ready(rdy1), .coll_cnt(cc1), .oor_err(oor1)
    );

    algo_1r2w_a63_mem_bank #(.SRAM_DELAY(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .t1_writeA(wa), .t1_addrA(aa), .t1_dinA(da), .t1_bwA(bw),
        .t1_readB(rb), .t1_addrB(ab),
`ifdef MEMOIR_MEM_ERRINJ_EN
        .errinj_en(ei_en), .errinj_bnk(ei_bnk), .errinj_row(ei_row), .errinj_mask(ei_mask),
`endif
        .t1_doutB(dout3), .ready(rdy3), .coll_cnt(cc3), .oor_err(oor3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        wa = '0; rb = '0; aa = '0; ab = '0; da = '0; bw = '0;
    endtask

    task automatic set_wr(input int b, input logic [BR-1:0] row, input logic [PW-1:0] d,
                          input logic [PW-1:0] m);
        wa[b] = 1'b1;
        aa[b*BR +: BR] = row;
        da[b*PW +: PW] = d;
        bw[b*PW +: PW] = m;
    endtask

    task automatic set_rd(input int b, input logic [BR-1:0] row);
        rb[b] = 1'b1;
        ab[b*BR +: BR] = row;
    endtask

    function automatic logic [PW-1:0] fval(input int b, input int k);
        return 32'hA0005A00 + 32'(b) * 32'h00100000 + 32'(k);
    endfunction

    task automatic test_reset();
        int n;
        clr();
        rst = 1'b0;
        repeat (3) tick();
        n_cmp++; if (rdy1 !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", rdy1); end
        n_cmp++; if (cc1 !== 16'h0) begin n_err++; $display("FAIL reset_coll: got %h want 0000", cc1); end
        n_cmp++; if (oor1 !== 1'b0) begin n_err++; $display("FAIL reset_oor: got %b want 0", oor1); end
        n_cmp++; if (dout1 !== '0) begin n_err++; $display("FAIL reset_dout: got %h want 0", dout1); end
        // strobes held through INIT must all be ignored
        set_wr(0, 10'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
        set_rd(0, 10'd3);
        set_wr(1, 10'd800, 32'hFFFFFFFF, 32'hFFFFFFFF);
        set_rd(1, 10'd800);
        rst = 1'b1;
        n = 0;
        while (!rdy1 && n < 1000) begin
            tick();
            n++;
        end
        n_cmp++; if (n !== 745) begin n_err++; $display("FAIL init_len: got %0d cycles want 745", n); end
        n_cmp++; if (rdy3 !== 1'b1) begin n_err++; $display("FAIL init_ready3: got %b want 1", rdy3); end
        n_cmp++; if (cc1 !== 16'h0) begin n_err++; $display("FAIL init_coll_ignored: got %h want 0000", cc1); end
        n_cmp++; if (oor1 !== 1'b0) begin n_err++; $display("FAIL init_oor_ignored: got %b want 0", oor1); end
        clr();
        set_rd(2, 10'd744);
        set_rd(0, 10'd3);
        tick();
        clr();
        n_cmp++; if (dout1[2*PW +: PW] !== 32'h0) begin n_err++; $display("FAIL init_row744: got %h want 00000000", dout1[2*PW +: PW]); end
        n_cmp++; if (dout1[0 +: PW] !== 32'h0) begin n_err++; $display("FAIL init_write_ignored: got %h want 00000000", dout1[0 +: PW]); end
    endtask

    task automatic test_masked_write();
        clr();
        set_wr(1, 10'd5, 32'hFFFFFFFF, 32'hFFFFFFFF);
        set_wr(3, 10'd0, 32'h12345678, 32'hFF00FF00);
        tick();
        clr();
        set_wr(1, 10'd5, 32'h00000000, 32'h0000FFFF);
        tick();
        clr();
        set_rd(1, 10'd5);
        set_rd(3, 10'd0);
        tick();
        clr();
        n_cmp++; if (dout1[1*PW +: PW] !== 32'hFFFF0000) begin n_err++; $display("FAIL masked_b1: got %h want ffff0000", dout1[1*PW +: PW]); end
        n_cmp++; if (dout1[3*PW +: PW] !== 32'h12005600) begin n_err++; $display("FAIL masked_b3: got %h want 12005600", dout1[3*PW +: PW]); end
        tick();
        n_cmp++; if (dout1[1*PW +: PW] !== 32'hFFFF0000) begin n_err++; $display("FAIL dout_hold: got %h want ffff0000", dout1[1*PW +: PW]); end
    endtask

    task automatic test_collision();
        clr();
        set_wr(0, 10'd7, 32'h11111111, 32'hFFFFFFFF);
        tick();
        clr();
        set_wr(0, 10'd7, 32'h22222222, 32'hFFFFFFFF);
        set_rd(0, 10'd7);
        tick();
        n_cmp++; if (dout1[0 +: PW] !== 32'h11111111) begin n_err++; $display("FAIL coll_rbw: got %h want 11111111", dout1[0 +: PW]); end
        n_cmp++; if (cc1 !== 16'd1) begin n_err++; $display("FAIL coll_cnt1: got %h want 0001", cc1); end
        clr();
        set_rd(0, 10'd7);
        set_wr(0, 10'd8, 32'h33333333, 32'hFFFFFFFF);
        tick();
        n_cmp++; if (dout1[0 +: PW] !== 32'h22222222) begin n_err++; $display("FAIL coll_after: got %h want 22222222", dout1[0 +: PW]); end
        n_cmp++; if (cc1 !== 16'd1) begin n_err++; $display("FAIL coll_diff_row: got %h want 0001", cc1); end
        clr();
        for (int b = 0; b < NB; b++) begin
            set_wr(b, 10'd10, 32'h0, 32'h0);
            set_rd(b, 10'd10);
        end
        repeat (16383) tick();
        n_cmp++; if (cc1 !== 16'd65533) begin n_err++; $display("FAIL coll_multi: got %0d want 65533", cc1); end
        tick();
        n_cmp++; if (cc1 !== 16'hFFFF) begin n_err++; $display("FAIL coll_sat: got %h want ffff", cc1); end
        tick();
        clr();
        n_cmp++; if (cc1 !== 16'hFFFF) begin n_err++; $display("FAIL coll_sat_hold: got %h want ffff", cc1); end
        n_cmp++; if (cc3 !== 16'hFFFF) begin n_err++; $display("FAIL coll_sat3: got %h want ffff", cc3); end
    endtask

    task automatic test_oor();
        clr();
        n_cmp++; if (oor1 !== 1'b0) begin n_err++; $display("FAIL oor_pre: got %b want 0", oor1); end
        set_wr(2, 10'd1, 32'hCAFEBABE, 32'hFFFFFFFF);
        tick();
        clr();
        set_rd(2, 10'd1);
        tick();
        clr();
        n_cmp++; if (dout1[2*PW +: PW] !== 32'hCAFEBABE) begin n_err++; $display("FAIL oor_base: got %h want cafebabe", dout1[2*PW +: PW]); end
        set_rd(2, 10'd800);
        tick();
        clr();
        n_cmp++; if (dout1[2*PW +: PW] !== 32'h0) begin n_err++; $display("FAIL oor_rd_data: got %h want 00000000", dout1[2*PW +: PW]); end
        n_cmp++; if (oor1 !== 1'b1) begin n_err++; $display("FAIL oor_set: got %b want 1", oor1); end
        repeat (3) tick();
        n_cmp++; if (oor1 !== 1'b1) begin n_err++; $display("FAIL oor_sticky: got %b want 1", oor1); end
        n_cmp++; if (oor3 !== 1'b1) begin n_err++; $display("FAIL oor_sticky3: got %b want 1", oor3); end
    endtask

    task automatic test_back_to_back();
        logic [PW-1:0] pre [NB];
        logic [PW-1:0] e1, e3;
        clr();
        for (int k = 0; k < 4; k++) begin
            clr();
            for (int b = 0; b < NB; b++) set_wr(b, BR'(20 + k), fval(b, k), 32'hFFFFFFFF);
            tick();
        end
        clr();
        for (int b = 0; b < NB; b++) set_rd(b, 10'd0);
        tick();
        clr();
        repeat (3) tick();
        pre[0] = 32'h0; pre[1] = 32'h0; pre[2] = 32'h0; pre[3] = 32'h12005600;
        for (int t = 0; t < 7; t++) begin
            clr();
            if (t < 4) for (int b = 0; b < NB; b++) set_rd(b, BR'(20 + t));
            tick();
            for (int b = 0; b < NB; b++) begin
                e1 = fval(b, (t < 4) ? t : 3);
                e3 = (t < 2) ? pre[b] : fval(b, (t - 2 < 3) ? t - 2 : 3);
                n_cmp++; if (dout1[b*PW +: PW] !== e1) begin n_err++; $display("FAIL stream_d1 t=%0d b=%0d: got %h want %h", t, b, dout1[b*PW +: PW], e1); end
                n_cmp++; if (dout3[b*PW +: PW] !== e3) begin n_err++; $display("FAIL stream_d3 t=%0d b=%0d: got %h want %h", t, b, dout3[b*PW +: PW], e3); end
            end
        end
        clr();
    endtask

    task automatic test_midinit_reset();
        int n;
        clr();
        n_cmp++; if (rdy1 !== 1'b1) begin n_err++; $display("FAIL pre_reset_ready: got %b want 1", rdy1); end
        rst = 1'b0;
        #1;
        n_cmp++; if (rdy1 !== 1'b0) begin n_err++; $display("FAIL async_ready_drop: got %b want 0", rdy1); end
        n_cmp++; if (oor1 !== 1'b0) begin n_err++; $display("FAIL reset_oor_clear: got %b want 0", oor1); end
        n_cmp++; if (cc1 !== 16'h0) begin n_err++; $display("FAIL reset_coll_clear: got %h want 0000", cc1); end
        n_cmp++; if (dout3 !== '0) begin n_err++; $display("FAIL reset_flush3: got %h want 0", dout3); end
        tick();
        rst = 1'b1;
        repeat (300) tick();
        n_cmp++; if (rdy1 !== 1'b0) begin n_err++; $display("FAIL midinit_ready: got %b want 0", rdy1); end
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        n = 0;
        while (!rdy1 && n < 1000) begin
            tick();
            n++;
        end
        n_cmp++; if (n !== 745) begin n_err++; $display("FAIL reinit_len: got %0d cycles want 745", n); end
        set_rd(0, 10'd20);
        set_rd(2, 10'd1);
        tick();
        clr();
        n_cmp++; if (dout1[0 +: PW] !== 32'h0) begin n_err++; $display("FAIL reinit_zero_b0: got %h want 00000000", dout1[0 +: PW]); end
        n_cmp++; if (dout1[2*PW +: PW] !== 32'h0) begin n_err++; $display("FAIL reinit_zero_b2: got %h want 00000000", dout1[2*PW +: PW]); end
    endtask

`ifdef MEMOIR_MEM_ERRINJ_EN
    task automatic test_errinj();
        clr();
        set_wr(3, 10'd9, 32'hA5A5A5A5, 32'hFFFFFFFF);
        set_wr(2, 10'd9, 32'h5A5A5A5A, 32'hFFFFFFFF);
        tick();
        clr();
        ei_en = 1'b1; ei_bnk = 2'd3; ei_row = 10'd9; ei_mask = 32'h00000001;
        set_rd(3, 10'd9);
        set_rd(2, 10'd9);
        tick();
        n_cmp++; if (dout1[3*PW +: PW] !== 32'hA5A5A5A4) begin n_err++; $display("FAIL errinj_on: got %h want a5a5a5a4", dout1[3*PW +: PW]); end
        n_cmp++; if (dout1[2*PW +: PW] !== 32'h5A5A5A5A) begin n_err++; $display("FAIL errinj_other_bank: got %h want 5a5a5a5a", dout1[2*PW +: PW]); end
        clr();
        ei_en = 1'b0;
        set_rd(3, 10'd9);
        tick();
        clr();
        n_cmp++; if (dout1[3*PW +: PW] !== 32'hA5A5A5A5) begin n_err++; $display("FAIL errinj_off: got %h want a5a5a5a5", dout1[3*PW +: PW]); end
        tick();
        n_cmp++; if (dout3[3*PW +: PW] !== 32'hA5A5A5A4) begin n_err++; $display("FAIL errinj_issue_sample: got %h want a5a5a5a4", dout3[3*PW +: PW]); end
        tick();
        n_cmp++; if (dout3[3*PW +: PW] !== 32'hA5A5A5A5) begin n_err++; $display("FAIL errinj_off3: got %h want a5a5a5a5", dout3[3*PW +: PW]); end
    endtask
`endif

    initial begin
        test_reset();
        test_masked_write();
        test_collision();
        test_oor();
        test_back_to_back();
        test_midinit_reset();
`ifdef MEMOIR_MEM_ERRINJ_EN
        test_errinj();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
